// File: rtl/dm_pkg.sv
// Shared types for the MEM-stage data-memory access unit: DMType codes, FSM states,
// byte-enable constants and the alignment check used when DM_MISALIGN_TRAP_EN is defined.
package dm_pkg;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_H_LO = 4'b0011;
  localparam logic [3:0] BE_H_HI = 4'b1100;
  localparam logic [3:0] BE_B0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } dm_state_e;

  // Unlisted codes 101-111 are treated as word accesses.
  function automatic logic dm_misaligned(input logic [2:0] t, input logic [1:0] lo);
    case (t)
      DM_H, DM_HU: return lo[0];
      DM_B, DM_BU: return 1'b0;
      default:     return (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Data-bus interface between dm_access_unit (master) and data memory (slave).
interface dm_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ready;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational lane steering: store byte enables / lane-replicated write data, and
// load lane selection with sign or zero extension.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  i_dm_type,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_raw,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = i_addr_lo[1] ? i_rdata_raw[31:16] : i_rdata_raw[15:0];
  assign w_byte = i_rdata_raw[{i_addr_lo, 3'b000} +: 8];

  always_comb begin
    o_be    = BE_ALL;
    o_wdata = i_wdata;
    o_rdata = i_rdata_raw;
    case (i_dm_type)
      DM_H, DM_HU: begin
        o_be    = i_addr_lo[1] ? BE_H_HI : BE_H_LO;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = (i_dm_type == DM_HU) ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      end
      DM_B, DM_BU: begin
        o_be    = BE_B0 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = (i_dm_type == DM_BU) ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      default: begin
        o_be    = BE_ALL;
        o_wdata = i_wdata;
        o_rdata = i_rdata_raw;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory master: one request/ready bus transaction per load/store, stalls the
// pipeline meanwhile. Optional feature: define DM_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        dm_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              bus_err,
  output logic              misalign_err,
  dm_access_unit_if.master  bus
);

  localparam int unsigned   CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dm_state_e         r_state, w_next;
  logic [2:0]        r_type;
  logic [1:0]        r_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic              r_done, r_bus_err, r_mis;
  logic              r_bus_req, r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_be;
  logic [31:0]       r_bus_wdata;

  logic              w_mis, w_timeout;
  logic [2:0]        w_al_type;
  logic [1:0]        w_al_lo;
  logic [3:0]        w_al_be;
  logic [31:0]       w_al_wdata, w_al_rdata;

`ifdef DM_MISALIGN_TRAP_EN
  assign w_mis = dm_misaligned(dm_type, addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  // One aligner serves both directions: live inputs steer the store in IDLE,
  // the latched type/offset extend the load word while in BUS.
  assign w_al_type = (r_state == ST_IDLE) ? dm_type   : r_type;
  assign w_al_lo   = (r_state == ST_IDLE) ? addr[1:0] : r_lo;

  dm_lane_align u_align (
    .i_dm_type   (w_al_type),
    .i_addr_lo   (w_al_lo),
    .i_wdata     (wdata),
    .i_rdata_raw (bus.bus_rdata),
    .o_be        (w_al_be),
    .o_wdata     (w_al_wdata),
    .o_rdata     (w_al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (mem_req) w_next = w_mis ? ST_DONE : ST_BUS;
      ST_BUS:  if (bus.bus_ready || w_timeout) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_type      <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_done      <= 1'b0;
      r_bus_err   <= 1'b0;
      r_mis       <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_done    <= 1'b0;
      r_bus_err <= 1'b0;
      r_mis     <= 1'b0;
      r_rdata   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (mem_req) begin
            r_type <= dm_type;
            r_lo   <= addr[1:0];
            r_cnt  <= '0;
            if (w_mis) begin
              r_done <= 1'b1;
              r_mis  <= 1'b1;
            end else begin
              r_bus_req   <= 1'b1;
              r_bus_we    <= mem_we;
              r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              r_bus_be    <= mem_we ? w_al_be : BE_ALL;
              r_bus_wdata <= mem_we ? w_al_wdata : '0;
            end
          end
        end
        ST_BUS: begin
          r_cnt <= r_cnt + 1'b1;
          // bus_ready takes priority over a simultaneous timeout expiry.
          if (bus.bus_ready || w_timeout) begin
            r_done      <= 1'b1;
            r_bus_err   <= ~bus.bus_ready;
            r_rdata     <= (bus.bus_ready && !r_bus_we) ? w_al_rdata : '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall        = !rst && (((r_state == ST_IDLE) && mem_req) || (r_state == ST_BUS));
  assign rdata        = r_rdata;
  assign done         = r_done;
  assign bus_err      = r_bus_err;
  assign misalign_err = r_mis;

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;

endmodule
